// File: rtl/robs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : robs_pkg                                                |
// | Purpose  : Shared types and constants for the Robertson divider    |
// |            (FSM state encoding, control word, counter width).      |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package robs_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  // Control unit states, explicitly encoded
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Control word from the FSM to the datapath
  typedef struct packed {
    logic load;   // form magnitudes, resolve early exits, arm counter
    logic shift;  // one restoring step of {rem,q}
    logic sub;    // subtract divisor in this step (sets q[0])
    logic neg_q;  // commit signed, range-checked quotient
    logic neg_r;  // commit signed, range-checked remainder
    logic clr;    // capture operands on an accepted start
  } ctrl_t;

  // Counter width for an arbitrary operand width (at least one bit)
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/robs_div_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : robs_div_datapath                                       |
// | Purpose  : Operand registers, restoring shift/subtract pair,       |
// |            sign correction, range check and iteration counter.     |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module robs_div_datapath
  import robs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  ctrl_t                ctrl,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 ge,
  output logic                 cnt_zero,
  output logic                 dz,
  output logic                 ovf_early,
  output logic                 ovf_fix,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] c_qmax_pos = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_qmax_neg = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_q;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;

  logic               w_dvd_neg;
  logic               w_dvs_neg;
  logic               w_q_neg;
  logic [2*WIDTH-1:0] w_dvd_mag;
  logic [WIDTH:0]     w_dvs_mag;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH-1:0]   w_rem_diff;
  logic [WIDTH-1:0]   w_q_signed;
  logic [WIDTH-1:0]   w_r_signed;

  // Magnitudes are kept unsigned so the most-negative operands do not wrap
  always_comb begin
    w_dvd_neg  = r_dvd[2*WIDTH-1];
    w_dvs_neg  = r_dvs[WIDTH-1];
    w_q_neg    = w_dvd_neg ^ w_dvs_neg;
    w_dvd_mag  = w_dvd_neg ? -r_dvd : r_dvd;
    w_dvs_mag  = {1'b0, (w_dvs_neg ? -r_dvs : r_dvs)};
    // Shifted remainder is one bit wider than the stored one so the compare is exact
    w_rem_sh   = {r_rem, r_q[WIDTH-1]};
    // Difference is always below 2^(WIDTH-1) when taken, so WIDTH bits suffice
    w_rem_diff = w_rem_sh[WIDTH-1:0] - w_dvs_mag[WIDTH-1:0];
    w_q_signed = w_q_neg   ? -r_q   : r_q;
    w_r_signed = w_dvd_neg ? -r_rem : r_rem;
  end

  assign ge        = (w_rem_sh >= w_dvs_mag);
  assign cnt_zero  = (r_cnt == '0);
  assign dz        = (r_dvs == '0);
  assign ovf_early = ({1'b0, w_dvd_mag[2*WIDTH-1:WIDTH]} >= w_dvs_mag);
  assign ovf_fix   = w_q_neg ? (r_q > c_qmax_neg) : (r_q > c_qmax_pos);

  // Operand capture on an accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dvd <= '0;
      r_dvs <= '0;
    end else if (ctrl.clr) begin
      r_dvd <= dividend;
      r_dvs <= divisor;
    end
  end

  // Working remainder/quotient pair and iteration counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rem <= '0;
      r_q   <= '0;
      r_cnt <= '0;
    end else if (ctrl.load) begin
      r_rem <= w_dvd_mag[2*WIDTH-1:WIDTH];
      r_q   <= w_dvd_mag[WIDTH-1:0];
      r_cnt <= CW'(WIDTH-1);
    end else if (ctrl.shift) begin
      r_rem <= ctrl.sub ? w_rem_diff : w_rem_sh[WIDTH-1:0];
      r_q   <= {r_q[WIDTH-2:0], ctrl.sub};
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Result registers: early exits resolve in LOAD, normal results in FIX
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      if (ctrl.load) begin
        if (dz) begin
          r_quotient  <= '1;
          r_remainder <= r_dvd[WIDTH-1:0];
        end else if (ovf_early) begin
          r_quotient  <= '0;
          r_remainder <= '0;
        end
      end
      if (ctrl.neg_q) begin
        r_quotient <= ovf_fix ? '0 : w_q_signed;
      end
      if (ctrl.neg_r) begin
        r_remainder <= ovf_fix ? '0 : w_r_signed;
      end
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;

endmodule
`default_nettype wire

// File: rtl/robs_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : robs_divider                                            |
// | Purpose  : Signed sequential divider (2W / W -> W quotient and     |
// |            remainder), one quotient bit per clock. Holds the FSM   |
// |            control unit and instantiates the datapath.             |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module robs_divider
  import robs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 div_zero,
  output logic                 overflow
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;

  logic   r_busy;
  logic   r_done;
  logic   r_div_zero;
  logic   r_overflow;

  logic   w_ge;
  logic   w_cnt_zero;
  logic   w_dz;
  logic   w_ovf_early;
  logic   w_ovf_fix;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and control word; start is ignored during the done pulse
  always_comb begin
    w_next = r_state;
    w_ctrl = '0;
    unique case (r_state)
      IDLE: begin
        if (start && !r_done) begin
          w_ctrl.clr = 1'b1;
          w_next     = LOAD;
        end
      end
      LOAD: begin
        w_ctrl.load = 1'b1;
        w_next      = (w_dz || w_ovf_early) ? DONE : ITER;
      end
      ITER: begin
        w_ctrl.shift = 1'b1;
        w_ctrl.sub   = w_ge;
        if (w_cnt_zero) begin
          w_next = FIX;
        end
      end
      FIX: begin
        w_ctrl.neg_q = 1'b1;
        w_ctrl.neg_r = 1'b1;
        w_next       = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Handshake: busy spans the computation, done pulses once after DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      if (w_ctrl.clr) begin
        r_busy <= 1'b1;
      end else if (w_next == DONE) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Status flags, cleared on an accepted start and held until the next one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_zero <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_ctrl.clr) begin
      r_div_zero <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_ctrl.load && w_dz) begin
        r_div_zero <= 1'b1;
      end
      if ((w_ctrl.load && !w_dz && w_ovf_early) || (w_ctrl.neg_q && w_ovf_fix)) begin
        r_overflow <= 1'b1;
      end
    end
  end

  robs_div_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .ctrl      (w_ctrl),
    .dividend  (dividend),
    .divisor   (divisor),
    .ge        (w_ge),
    .cnt_zero  (w_cnt_zero),
    .dz        (w_dz),
    .ovf_early (w_ovf_early),
    .ovf_fix   (w_ovf_fix),
    .quotient  (quotient),
    .remainder (remainder)
  );

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_robs_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_robs_divider                                         |
// | Purpose  : Self-checking bench for robs_divider (WIDTH=8): vector  |
// |            table, abort/ignore sequences and a random sweep.       |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_robs_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        overflow;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    logic        ov;
    int          lat;
  } vec_t;

  vec_t vecs [16];

  robs_divider #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one divide (caller is #1 after a rising edge) and wait for done
  task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output logic ov,
                         output int lat, output int bcnt);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bcnt  = busy ? 1 : 0;
    lat   = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (!done && busy) bcnt++;
    end
    q  = quotient;
    r  = remainder;
    dz = div_zero;
    ov = overflow;
  endtask

  initial begin
    logic [7:0] q, r;
    logic       dz, ov;
    int         lat, bcnt;

    n_tests = 0;
    n_fail  = 0;

    //            dividend  divisor  q      r      dz    ov    lat
    vecs[0]  = '{16'd100,  8'd7,    8'h0E, 8'h02, 1'b0, 1'b0, 11};
    vecs[1]  = '{16'hFF9C, 8'd7,    8'hF2, 8'hFE, 1'b0, 1'b0, 11};
    vecs[2]  = '{16'd100,  8'hF9,   8'hF2, 8'h02, 1'b0, 1'b0, 11};
    vecs[3]  = '{16'hFF9C, 8'hF9,   8'h0E, 8'hFE, 1'b0, 1'b0, 11};
    vecs[4]  = '{16'h0123, 8'h00,   8'hFF, 8'h23, 1'b1, 1'b0, 2};
    vecs[5]  = '{16'h4000, 8'd2,    8'h00, 8'h00, 1'b0, 1'b1, 2};
    vecs[6]  = '{16'h0100, 8'd2,    8'h00, 8'h00, 1'b0, 1'b1, 11};
    vecs[7]  = '{16'hFF00, 8'd2,    8'h80, 8'h00, 1'b0, 1'b0, 11};
    vecs[8]  = '{16'h8000, 8'hFF,   8'h00, 8'h00, 1'b0, 1'b1, 2};
    vecs[9]  = '{16'hFF80, 8'h80,   8'h01, 8'h00, 1'b0, 1'b0, 11};
    vecs[10] = '{16'h3F01, 8'h7F,   8'h7F, 8'h00, 1'b0, 1'b0, 11};
    vecs[11] = '{16'h7FFF, 8'h80,   8'h00, 8'h00, 1'b0, 1'b1, 11};
    vecs[12] = '{16'hC000, 8'h80,   8'h00, 8'h00, 1'b0, 1'b1, 11};
    vecs[13] = '{16'h8000, 8'h7F,   8'h00, 8'h00, 1'b0, 1'b1, 2};
    vecs[14] = '{16'h0000, 8'd5,    8'h00, 8'h00, 1'b0, 1'b0, 11};
    vecs[15] = '{16'hFFF9, 8'd100,  8'h00, 8'hF9, 1'b0, 1'b0, 11};

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_q",    int'(quotient),  0);
    check("reset_r",    int'(remainder), 0);
    check("reset_busy", int'(busy),      0);
    check("reset_done", int'(done),      0);
    check("reset_dz",   int'(div_zero),  0);
    check("reset_ovf",  int'(overflow),  0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed vector table, issued back-to-back one cycle after each done
    for (int i = 0; i < 16; i++) begin
      run_div(vecs[i].a, vecs[i].b, q, r, dz, ov, lat, bcnt);
      check($sformatf("v%0d_q", i),   int'(q),  int'(vecs[i].q));
      check($sformatf("v%0d_r", i),   int'(r),  int'(vecs[i].r));
      check($sformatf("v%0d_dz", i),  int'(dz), int'(vecs[i].dz));
      check($sformatf("v%0d_ovf", i), int'(ov), int'(vecs[i].ov));
      check($sformatf("v%0d_lat", i), lat,      vecs[i].lat);
      if (i == 0) check("v0_busy_cycles", bcnt, 10);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), int'(done), 0);
    end

    // Start pulsed during ITER must be ignored
    dividend = 16'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    dividend = 16'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 5;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ign_lat", lat, 11);
    check("ign_q", int'(quotient),  8'h0E);
    check("ign_r", int'(remainder), 8'h02);
    @(posedge clk); #1;
    check("ign_idle", int'(busy), 0);

    // Reset mid-ITER clears every output immediately
    dividend = 16'hFF9C;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("abort_q",    int'(quotient),  0);
    check("abort_r",    int'(remainder), 0);
    check("abort_busy", int'(busy),      0);
    check("abort_done", int'(done),      0);
    check("abort_dz",   int'(div_zero),  0);
    check("abort_ovf",  int'(overflow),  0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_div(16'hFF9C, 8'd7, q, r, dz, ov, lat, bcnt);
    check("after_abort_q",   int'(q),  8'hF2);
    check("after_abort_r",   int'(r),  8'hFE);
    check("after_abort_lat", lat,      11);
    check("after_abort_ovf", int'(ov), 0);
    @(posedge clk); #1;

    // Random signed sweep against integer division
    for (int k = 0; k < 40; k++) begin
      logic [15:0] a;
      logic [7:0]  b;
      int          ai, bi, qi, ri;
      logic [7:0]  eq, er;
      logic        edz, eov;
      if ($urandom_range(0, 1) == 1) begin
        int x, y;
        x = int'($urandom_range(0, 255)) - 128;
        y = int'($urandom_range(0, 255)) - 128;
        a = 16'(x * y + int'($urandom_range(0, 5)));
      end else begin
        a = 16'($urandom);
      end
      b = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      ai = int'($signed(a));
      bi = int'($signed(b));
      edz = 1'b0;
      eov = 1'b0;
      if (bi == 0) begin
        edz = 1'b1;
        eq  = 8'hFF;
        er  = a[7:0];
      end else begin
        qi = ai / bi;
        ri = ai % bi;
        if (qi > 127 || qi < -128) begin
          eov = 1'b1;
          eq  = 8'h00;
          er  = 8'h00;
        end else begin
          eq = qi[7:0];
          er = ri[7:0];
        end
      end
      run_div(a, b, q, r, dz, ov, lat, bcnt);
      check($sformatf("rnd%0d_done %h/%h", k, a, b), int'(lat < 40), 1);
      check($sformatf("rnd%0d_q %h/%h", k, a, b),   int'(q),  int'(eq));
      check($sformatf("rnd%0d_r %h/%h", k, a, b),   int'(r),  int'(er));
      check($sformatf("rnd%0d_flags %h/%h", k, a, b), int'({dz, ov}), int'({edz, eov}));
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
